// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S frame feeder and its stereo FIFO.
package audio_pkg;

  localparam int I2S_BITS_PER_CH    = 32;
  localparam int I2S_BITS_PER_FRAME = 64;
  localparam int DW_DEFAULT         = 16;
  localparam int BIT_CNT_W          = $clog2(I2S_BITS_PER_FRAME);

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  typedef struct packed {
    logic [DW_DEFAULT-1:0] left;
    logic [DW_DEFAULT-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/audio_i2s_frame_feeder_if.sv
// Sample handshake between the synth engine (master) and the frame feeder (slave).
interface audio_i2s_frame_feeder_if #(
  parameter int DW = 16
);

  logic [DW-1:0] i_lsample;
  logic [DW-1:0] i_rsample;
  logic          i_valid;
  logic          o_ready;

  modport master (output i_lsample, output i_rsample, output i_valid, input o_ready);
  modport slave  (input i_lsample, input i_rsample, input i_valid, output o_ready);

endinterface

// File: rtl/audio_stereo_fifo.sv
// Single-clock FIFO of stereo sample pairs; push/pop are ignored when full/empty.
module audio_stereo_fifo
  import audio_pkg::*;
#(
  parameter int  AW     = 2,
  parameter type elem_t = stereo_sample_t
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  elem_t       din,
  input  logic        pop,
  output elem_t       dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  localparam int DEPTH = 1 << AW;

  elem_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the level counter alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      level <= level + 1'b1;
      else if (!push_ok && pop_ok) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/audio_i2s_frame_feeder.sv
// Generates I2S BCK/LRCK from mCLK and hands one buffered stereo pair to the
// serializer at every frame start.
module audio_i2s_frame_feeder
  import audio_pkg::*;
#(
  parameter int BCK_HALF = 4,
  parameter int FIFO_AW  = 2,
  parameter int DW       = DW_DEFAULT
) (
  input  logic                   mCLK,
  input  logic                   iRST_N,
  audio_i2s_frame_feeder_if.slave s_if,
  output logic                   oAUD_BCK,
  output logic                   oAUD_LRCK,
  output logic [DW-1:0]          o_lsound_out,
  output logic [DW-1:0]          o_rsound_out,
  output logic                   o_frame_tick,
  output logic                   o_underrun,
  output logic [FIFO_AW:0]       o_level
);

  localparam int             DIV_W    = $clog2(BCK_HALF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_HALF - 1);
  localparam bit_cnt_t       LAST_BIT = bit_cnt_t'(I2S_BITS_PER_FRAME - 1);
  localparam bit_cnt_t       CH_BITS  = bit_cnt_t'(I2S_BITS_PER_CH);

  typedef struct packed {
    logic [DW-1:0] left;
    logic [DW-1:0] right;
  } pair_t;

  logic [DIV_W-1:0] div_cnt;
  bit_cnt_t         bit_cnt;
  bit_cnt_t         bit_next;
  logic             div_wrap;
  logic             bck_fall;
  logic             frame_start;
  logic             full;
  logic             empty;
  pair_t            push_data;
  pair_t            head;

  assign div_wrap    = (div_cnt == DIV_LAST);
  assign bck_fall    = div_wrap & oAUD_BCK;
  assign frame_start = bck_fall & (bit_cnt == LAST_BIT);
  assign bit_next    = bit_cnt + 1'b1;
  assign push_data   = {s_if.i_lsample, s_if.i_rsample};
  assign s_if.o_ready = ~full;

  // Pop is driven by the registered empty flag, so a push landing on a
  // frame-start edge is never bypassed into the outputs.
  audio_stereo_fifo #(
    .AW     (FIFO_AW),
    .elem_t (pair_t)
  ) u_fifo (
    .clk   (mCLK),
    .rst_n (iRST_N),
    .push  (s_if.i_valid),
    .din   (push_data),
    .pop   (frame_start),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (o_level)
  );

  always_ff @(posedge mCLK) begin
    if (!iRST_N) begin
      div_cnt      <= '0;
      oAUD_BCK     <= 1'b0;
      bit_cnt      <= LAST_BIT;
      oAUD_LRCK    <= 1'b0;
      o_lsound_out <= '0;
      o_rsound_out <= '0;
      o_frame_tick <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) oAUD_BCK <= ~oAUD_BCK;
      if (bck_fall) begin
        bit_cnt   <= bit_next;
        oAUD_LRCK <= (bit_next < CH_BITS);
      end
      o_frame_tick <= frame_start;
      o_underrun   <= frame_start & empty;
      if (frame_start && !empty) begin
        o_lsound_out <= head.left;
        o_rsound_out <= head.right;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_frame_feeder.sv
// Drives two feeder configurations with shared stimulus and compares them to a
// cycle-count/queue reference model.
module tb_audio_i2s_frame_feeder;

  localparam int DW  = 16;
  localparam int BH0 = 4;
  localparam int AW0 = 2;
  localparam int BH1 = 2;
  localparam int AW1 = 3;

  logic          mclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] lsample = '0;
  logic [DW-1:0] rsample = '0;

  always #5 mclk = ~mclk;

  audio_i2s_frame_feeder_if #(.DW(DW)) if0 ();
  audio_i2s_frame_feeder_if #(.DW(DW)) if1 ();

  assign if0.i_valid   = valid;
  assign if0.i_lsample = lsample;
  assign if0.i_rsample = rsample;
  assign if1.i_valid   = valid;
  assign if1.i_lsample = lsample;
  assign if1.i_rsample = rsample;

  logic bck0, lrck0, tick0, und0;
  logic bck1, lrck1, tick1, und1;
  logic [DW-1:0] lo0, ro0, lo1, ro1;
  logic [AW0:0]  lvl0;
  logic [AW1:0]  lvl1;

  audio_i2s_frame_feeder #(.BCK_HALF(BH0), .FIFO_AW(AW0), .DW(DW)) dut0 (
    .mCLK(mclk), .iRST_N(rst_n), .s_if(if0),
    .oAUD_BCK(bck0), .oAUD_LRCK(lrck0),
    .o_lsound_out(lo0), .o_rsound_out(ro0),
    .o_frame_tick(tick0), .o_underrun(und0), .o_level(lvl0)
  );

  audio_i2s_frame_feeder #(.BCK_HALF(BH1), .FIFO_AW(AW1), .DW(DW)) dut1 (
    .mCLK(mclk), .iRST_N(rst_n), .s_if(if1),
    .oAUD_BCK(bck1), .oAUD_LRCK(lrck1),
    .o_lsound_out(lo1), .o_rsound_out(ro1),
    .o_frame_tick(tick1), .o_underrun(und1), .o_level(lvl1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state, one slot per configuration.
  int               bh    [2] = '{BH0, BH1};
  int               depth [2] = '{1 << AW0, 1 << AW1};
  int               n     [2];
  logic [2*DW-1:0]  q0 [$];
  logic [2*DW-1:0]  q1 [$];
  logic [DW-1:0]    el [2];
  logic [DW-1:0]    er [2];
  bit               et [2];
  bit               eu [2];
  bit               mready [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Frame starts fall on every 64th BCK falling edge, the first one
  // 2*BCK_HALF cycles after reset release.
  task automatic model_edge(input int k);
    logic [2*DW-1:0] v;
    bit fs;
    if (!rst_n) begin
      n[k] = 0;
      if (k == 0) q0.delete(); else q1.delete();
      el[k] = '0; er[k] = '0; et[k] = 0; eu[k] = 0;
      return;
    end
    n[k]++;
    fs = (n[k] >= 2*bh[k]) && ((n[k] - 2*bh[k]) % (128*bh[k]) == 0);
    et[k] = fs;
    eu[k] = 0;
    if (fs) begin
      if (qsize(k) == 0) eu[k] = 1;
      else begin
        if (k == 0) v = q0.pop_front(); else v = q1.pop_front();
        el[k] = v[2*DW-1:DW];
        er[k] = v[DW-1:0];
      end
    end
    if (valid && mready[k]) begin
      if (k == 0) q0.push_back({lsample, rsample}); else q1.push_back({lsample, rsample});
    end
  endtask

  task automatic compare(input int k);
    int  m;
    bit  exp_bck, exp_lrck;
    m        = n[k] / (2*bh[k]);
    exp_bck  = ((n[k] / bh[k]) % 2) == 1;
    exp_lrck = (m >= 1) && (((m - 1) % 64) < 32);
    check($sformatf("bck%0d", k),   (k == 0) ? bck0  : bck1,  exp_bck);
    check($sformatf("lrck%0d", k),  (k == 0) ? lrck0 : lrck1, exp_lrck);
    check($sformatf("tick%0d", k),  (k == 0) ? tick0 : tick1, et[k]);
    check($sformatf("under%0d", k), (k == 0) ? und0  : und1,  eu[k]);
    check($sformatf("lout%0d", k),  (k == 0) ? lo0   : lo1,   el[k]);
    check($sformatf("rout%0d", k),  (k == 0) ? ro0   : ro1,   er[k]);
    check($sformatf("level%0d", k), (k == 0) ? 64'(lvl0) : 64'(lvl1), qsize(k));
  endtask

  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      mready[k] = qsize(k) < depth[k];
      check($sformatf("ready%0d", k), (k == 0) ? if0.o_ready : if1.o_ready, mready[k]);
    end
    @(posedge mclk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      model_edge(k);
      compare(k);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
    valid   = v;
    lsample = l;
    rsample = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0);
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    @(posedge mclk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_edge(k);
      compare(k);
    end

    // Free-run with no pushes: underrun at each frame start, outputs stay 0.
    do_reset();
    for (int c = 1; c <= 530; c++) cycle();

    // Two directed pairs queued ahead of the first frame start.
    do_reset();
    drive(1'b1, 16'h1234, 16'hABCD); cycle();
    drive(1'b1, 16'h8000, 16'h7FFF); cycle();
    drive(1'b0, '0, '0);
    for (int c = 3; c <= 530; c++) cycle();

    // Continuous valid: fill to full, drop extras, resume after each pop.
    do_reset();
    for (int c = 1; c <= 600; c++) begin
      drive(1'b1, DW'($urandom), DW'($urandom));
      cycle();
    end

    // Pushes landing exactly on frame-start edges into an empty FIFO.
    do_reset();
    for (int c = 1; c <= 530; c++) begin
      if (c == 2*BH0 || c == 2*BH1 + 128*BH1) drive(1'b1, DW'($urandom), DW'($urandom));
      else drive(1'b0, '0, '0);
      cycle();
    end

    // Mid-operation reset with entries queued.
    do_reset();
    for (int c = 1; c <= 299; c++) begin
      if (c <= 4) drive(1'b1, DW'($urandom), DW'($urandom));
      else drive(1'b0, '0, '0);
      cycle();
    end
    do_reset();
    for (int c = 1; c <= 600; c++) cycle();

    // Sparse random traffic with occasional resets.
    do_reset();
    for (int c = 1; c <= 3000; c++) begin
      drive($urandom_range(0, 99) < 2, DW'($urandom), DW'($urandom));
      if ($urandom_range(0, 1999) == 0) do_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_i2s_frame_feeder.md
Name: audio_i2s_frame_feeder

Overview:
Upstream neighbour of the I2S serializer. From the single system clock it generates the I2S bit clock (oAUD_BCK) and the left/right clock (oAUD_LRCK), 32 bits per channel. It buffers stereo 16-bit samples from the synth engine in a small FIFO with a valid/ready handshake. Once per frame it presents a stable left/right pair to the serializer.

Parameters:
BCK_HALF, 4, mCLK cycles per BCK half-period (≥2); BCK = mCLK/(2*BCK_HALF)
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW stereo entries
DW, 16, sample width per channel

Ports:
mCLK  in  1  system clock, all logic on rising edge
iRST_N  in  1  synchronous active-low reset
i_lsample  in  DW  left sample from synth engine
i_rsample  in  DW  right sample from synth engine
i_valid  in  1  sample pair valid
o_ready  out  1  FIFO can accept; transfer when i_valid && o_ready
oAUD_BCK  out  1  I2S bit clock, registered
oAUD_LRCK  out  1  I2S LR clock, registered; high = first half of frame
o_lsound_out  out  DW  left sample to serializer, registered
o_rsound_out  out  DW  right sample to serializer, registered
o_frame_tick  out  1  one-cycle pulse at frame start (sample request to engine)
o_underrun  out  1  one-cycle pulse: frame start found FIFO empty
o_level  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (iRST_N=0 at a mCLK edge): div_cnt=0, oAUD_BCK=0, bit_cnt=63, oAUD_LRCK=0, FIFO empty, o_level=0, o_ready=1 after reset, o_lsound_out=o_rsound_out=0, o_frame_tick=0, o_underrun=0. Mid-operation reset discards FIFO contents and restarts timing identically.
- Clock divider: div_cnt counts 0..BCK_HALF-1 and wraps. On wrap oAUD_BCK toggles.
- bit_cnt (6 bits) increments, wrapping 63→0, on the edge where oAUD_BCK toggles 1→0.
- oAUD_LRCK = 1 while bit_cnt in 0..31, 0 while 32..63. It is registered and changes on the same edge as the BCK falling edge.
- Frame start is the edge where bit_cnt wraps 63→0. The first one falls 2*BCK_HALF cycles after reset release (cycle 8 at default). It then repeats every 128*BCK_HALF cycles (512 at default).
- At frame start, on the same edge:
  - o_frame_tick=1.
  - FIFO non-empty: pop head and load o_lsound_out/o_rsound_out.
  - FIFO empty: hold previous outputs and pulse o_underrun.
  - Outputs are otherwise constant for the whole frame. The serializer samples them mid-frame.
- FIFO behaviour:
  - o_ready = !full, computed from registered state.
  - Push when i_valid && o_ready.
  - Simultaneous push and pop when non-empty: level unchanged, order preserved.
  - Push into an empty FIFO on a frame-start edge is not bypassed. The pop sees empty, so an underrun is reported and the pushed pair is used next frame.
  - Push while full is ignored (o_ready=0, so none is accepted). Pop-while-full frees a slot, but o_ready rises only on the following cycle.
  - Pointers wrap modulo depth. o_level ranges 0..2**FIFO_AW.
- No combinational paths from inputs to outputs.

Decomposition:
- Shared package audio_pkg:
  - I2S_BITS_PER_CH=32, I2S_BITS_PER_FRAME=64, DW default 16.
  - Typedef stereo_sample_t {left, right}.
- Sub-module audio_stereo_fifo: synchronous single-clock FIFO of stereo_sample_t with push/pop, full/empty, level. The top holds the divider, bit counter and frame-start logic.

Test Plan:
- Reset then free-run, no pushes, defaults:
  - BCK period 8 cycles, first rise at cycle 4.
  - LRCK rises at cycle 8 and stays high 256 cycles, then low 256.
  - o_frame_tick at cycles 8 and 520.
  - o_underrun pulses both times; outputs stay 0.
- Push (L=0x1234,R=0xABCD) then (L=0x8000,R=0x7FFF) before cycle 8:
  - Outputs become 0x1234/0xABCD at cycle 8 and 0x8000/0x7FFF at cycle 520.
  - o_level goes 2→1→0; no underrun.
- Hold i_valid=1 continuously from reset:
  - o_level reaches 4, o_ready=0, extra data is dropped and not stored.
  - After the cycle-8 pop, o_ready=1 one cycle later.
  - Output sequence equals the accepted sequence with no duplicates.
- Push on exactly a frame-start edge into an empty FIFO:
  - o_underrun=1 at that edge and outputs held.
  - The pair appears at the next frame start; o_level=1 in between.
- Assert iRST_N=0 for 1 cycle at cycle 300 with 3 entries queued:
  - Next cycle o_level=0, BCK=0, LRCK=0, outputs 0.
  - The next frame tick is 8 cycles after reset release.
- BCK_HALF=2, FIFO_AW=3:
  - BCK period 4, frame ticks every 256 cycles.
  - o_ready drops at o_level=8.
